// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline-register defaults and the EX/MEM payload layout.
// The payload field order {regwrite, resultsrc, memwrite, aluresult, writedata, rd, pcplus4}
// is shared with the ID/EX and MEM/WB successors so they pack in the same way.
package riscv_pipe_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_REGW = 5;
  localparam int DEF_RSW  = 2;
  typedef struct packed {
    logic                regwrite;
    logic [DEF_RSW-1:0]  resultsrc;
    logic                memwrite;
    logic [DEF_XLEN-1:0] aluresult;
    logic [DEF_XLEN-1:0] writedata;
    logic [DEF_REGW-1:0] rd;
    logic [DEF_XLEN-1:0] pcplus4;
  } em_payload_t;
  function automatic int em_width(int xlen, int regw, int rsw);
    return 3 * xlen + regw + rsw + 2;
  endfunction
endpackage

// File: rtl/reg_em_elastic_if.sv
// reg_em_elastic_if: EX-side and MEM-side handshake channels of the EX/MEM register.
// slave  : the register's view (accepts from EX, presents to MEM).
// master : the surrounding pipeline's view (drives EX fields and ready_m).
interface reg_em_elastic_if import riscv_pipe_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int REGW = DEF_REGW,
  parameter int RSW  = DEF_RSW
);
  logic            valid_e, ready_e, regwrite_e, memwrite_e;
  logic [RSW-1:0]  resultsrc_e;
  logic [XLEN-1:0] aluresult, writedata_e, pcplus4_e;
  logic [REGW-1:0] rd_e;
  logic            valid_m, ready_m, regwrite_m, memwrite_m;
  logic [RSW-1:0]  resultsrc_m;
  logic [XLEN-1:0] aluresult_m, writedata_m, pcplus4_m;
  logic [REGW-1:0] rd_m;
  modport slave (
    input  valid_e, regwrite_e, resultsrc_e, memwrite_e, aluresult, writedata_e, rd_e, pcplus4_e, ready_m,
    output ready_e, valid_m, regwrite_m, resultsrc_m, memwrite_m, aluresult_m, writedata_m, rd_m, pcplus4_m
  );
  modport master (
    output valid_e, regwrite_e, resultsrc_e, memwrite_e, aluresult, writedata_e, rd_e, pcplus4_e, ready_m,
    input  ready_e, valid_m, regwrite_m, resultsrc_m, memwrite_m, aluresult_m, writedata_m, rd_m, pcplus4_m
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry skid buffer (main + skid) with synchronous flush.
// Ports: clk, rst_n (async active-low), flush; in_valid/in_ready/in_data from upstream;
// out_valid/out_ready/out_data to downstream (out_data is the main entry).
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_v, fire_in, fire_out, main_ld, skid_ld;
  logic [W-1:0] skid_d;
  // ready depends only on the registered skid bit, never on out_ready
  assign in_ready = !skid_v;
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;
  // main loads from skid when draining FULL, else from input when empty or being consumed
  assign main_ld  = !flush & (skid_v ? fire_out : fire_in & (!out_valid | fire_out));
  assign skid_ld  = !flush & out_valid & !skid_v & fire_in & !fire_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_v    <= 1'b0;
    end else begin
      out_valid <= !flush & (skid_v | fire_in | (out_valid & !fire_out));
      skid_v    <= skid_ld | (!flush & skid_v & !fire_out);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data <= '0;
      skid_d   <= '0;
    end else begin
      if (main_ld) out_data <= skid_v ? skid_d : in_data;
      if (skid_ld) skid_d <= in_data;
    end
endmodule

// File: rtl/reg_em_elastic.sv
// reg_em_elastic: elastic EX/MEM pipeline register with skid buffer, flush and stall counter.
// Ports: clk, rst_n (async active-low), flush (sync kill of held entries),
// bus (reg_em_elastic_if.slave: EX-side *_e fields + valid_e/ready_e, MEM-side *_m fields + valid_m/ready_m),
// stall_cnt (saturating count of cycles with valid_m=1 and ready_m=0).
module reg_em_elastic import riscv_pipe_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int REGW = DEF_REGW,
  parameter int RSW  = DEF_RSW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  reg_em_elastic_if.slave bus,
  output logic [CNTW-1:0] stall_cnt
);
  localparam int PW = em_width(XLEN, REGW, RSW);
  logic [PW-1:0]   in_d, out_d;
  logic            regwrite_q, memwrite_q;
  logic [REGW-1:0] rd_q;
  assign in_d = {bus.regwrite_e, bus.resultsrc_e, bus.memwrite_e, bus.aluresult,
                 bus.writedata_e, bus.rd_e, bus.pcplus4_e};
  assign {regwrite_q, bus.resultsrc_m, memwrite_q, bus.aluresult_m,
          bus.writedata_m, rd_q, bus.pcplus4_m} = out_d;
  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.valid_e),
    .in_ready  (bus.ready_e),
    .in_data   (in_d),
    .out_valid (bus.valid_m),
    .out_ready (bus.ready_m),
    .out_data  (out_d)
  );
  // side-effecting fields and rd are zeroed when invalid so hazard logic sees no writer
  assign bus.regwrite_m = bus.valid_m & regwrite_q;
  assign bus.memwrite_m = bus.valid_m & memwrite_q;
  assign bus.rd_m       = bus.valid_m ? rd_q : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (bus.valid_m & !bus.ready_m & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_reg_em_elastic.sv
// tb_reg_em_elastic: self-checking bench for reg_em_elastic (default CNTW plus a CNTW=4 copy).
// A negedge monitor pushes accepted inputs to a queue and pops/compares on every MEM transfer.
module tb_reg_em_elastic;
  import riscv_pipe_pkg::*;
  localparam int PW = em_width(DEF_XLEN, DEF_REGW, DEF_RSW);
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic valid_e = 1'b0, ready_m = 1'b0, regwrite_e = 1'b0, memwrite_e = 1'b0;
  logic [1:0]  resultsrc_e = '0;
  logic [31:0] aluresult = '0, writedata_e = '0, pcplus4_e = '0;
  logic [4:0]  rd_e = '0;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;
  int checks = 0, errors = 0;
  logic [PW-1:0] q[$];
  always #5 clk = ~clk;
  reg_em_elastic_if b0();
  reg_em_elastic_if b1();
  assign b0.valid_e = valid_e;         assign b1.valid_e = valid_e;
  assign b0.ready_m = ready_m;         assign b1.ready_m = ready_m;
  assign b0.regwrite_e = regwrite_e;   assign b1.regwrite_e = regwrite_e;
  assign b0.memwrite_e = memwrite_e;   assign b1.memwrite_e = memwrite_e;
  assign b0.resultsrc_e = resultsrc_e; assign b1.resultsrc_e = resultsrc_e;
  assign b0.aluresult = aluresult;     assign b1.aluresult = aluresult;
  assign b0.writedata_e = writedata_e; assign b1.writedata_e = writedata_e;
  assign b0.pcplus4_e = pcplus4_e;     assign b1.pcplus4_e = pcplus4_e;
  assign b0.rd_e = rd_e;               assign b1.rd_e = rd_e;
  reg_em_elastic dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0.slave), .stall_cnt(stall_cnt));
  reg_em_elastic #(.CNTW(4)) dut4 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1.slave), .stall_cnt(stall_cnt4));

  always @(negedge clk) begin
    logic [PW-1:0] exp_v, act_v;
    if (!rst_n) q.delete();
    else begin
      if (b0.valid_m && ready_m) begin
        act_v = {b0.regwrite_m, b0.resultsrc_m, b0.memwrite_m, b0.aluresult_m,
                 b0.writedata_m, b0.rd_m, b0.pcplus4_m};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h, expected nothing", act_v);
        end else begin
          exp_v = q.pop_front();
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL sb_payload: got %h, expected %h", act_v, exp_v);
          end
        end
      end
      if (flush) q.delete();
      else if (valid_e && b0.ready_e)
        q.push_back({regwrite_e, resultsrc_e, memwrite_e, aluresult, writedata_e, rd_e, pcplus4_e});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic [31:0] alu);
    valid_e = v; rd_e = rd; aluresult = alu;
    writedata_e = ~alu; pcplus4_e = alu + 32'd4;
    regwrite_e = rd[0]; memwrite_e = rd[1]; resultsrc_e = rd[3:2];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [PW+1:0] outs;
    rst_n = 1'b0;
    set_in(1'b1, 5'd31, 32'hDEADBEEF);
    ready_m = 1'b1;
    tick();
    tick();
    outs = {b0.valid_m, b0.regwrite_m, b0.resultsrc_m, b0.memwrite_m, b0.aluresult_m,
            b0.writedata_m, b0.rd_m, b0.pcplus4_m};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h, expected 0", outs); end
    checks++;
    if (b0.ready_e !== 1'b1) begin errors++; $display("FAIL reset_ready_e: got %b, expected 1", b0.ready_e); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt); end
    set_in(1'b0, 5'd0, 32'd0);
    ready_m = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] vals [3] = '{32'hFFFF0001, 32'hFFFF0100, 32'hFFFF0200};
    ready_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'(i + 1), vals[i]);
      tick();
      checks++;
      if (b0.valid_m !== 1'b1 || b0.aluresult_m !== vals[i]) begin
        errors++;
        $display("FAIL stream_%0d: got valid_m=%b alu=%h, expected valid_m=1 alu=%h", i, b0.valid_m, b0.aluresult_m, vals[i]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b0.valid_m !== 1'b0 || b0.aluresult_m !== 32'd0) begin
      errors++;
      $display("FAIL stream_async_reset: got valid_m=%b alu=%h, expected 0/0", b0.valid_m, b0.aluresult_m);
    end
    set_in(1'b0, 5'd0, 32'd0);
    ready_m = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [4:0] rds [3] = '{5'd17, 5'd9, 5'd3};
    logic [1:0] rdy_exp [3] = '{2'b11, 2'b10, 2'b10};
    ready_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rds[i], 32'h100 + 32'(i));
      tick();
      checks++;
      if ({b0.valid_m, b0.ready_e} !== rdy_exp[i] || b0.rd_m !== 5'd17) begin
        errors++;
        $display("FAIL bp_fill_%0d: got valid_m,ready_e=%b rd_m=%0d, expected %b rd_m=17", i, {b0.valid_m, b0.ready_e}, b0.rd_m, rdy_exp[i]);
      end
    end
    ready_m = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (b0.valid_m !== 1'b1 || b0.rd_m !== rds[i] || b0.ready_e !== 1'b1) begin
        errors++;
        $display("FAIL bp_drain_%0d: got valid_m=%b rd_m=%0d ready_e=%b, expected 1/%0d/1", i, b0.valid_m, b0.rd_m, b0.ready_e, rds[i]);
      end
    end
    set_in(1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (b0.valid_m !== 1'b0 || b0.rd_m !== 5'd0) begin
      errors++;
      $display("FAIL bp_empty: got valid_m=%b rd_m=%0d, expected 0/0", b0.valid_m, b0.rd_m);
    end
  endtask

  task automatic test_flush();
    ready_m = 1'b0;
    set_in(1'b1, 5'd11, 32'h11);
    tick();
    set_in(1'b1, 5'd12, 32'h12);
    tick();
    checks++;
    if (b0.ready_e !== 1'b0) begin errors++; $display("FAIL flush_full: got ready_e=%b, expected 0", b0.ready_e); end
    set_in(1'b1, 5'd5, 32'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, 5'd0, 32'd0);
    checks++;
    if ({b0.valid_m, b0.regwrite_m, b0.memwrite_m, b0.rd_m, b0.ready_e} !== 9'b000000001) begin
      errors++;
      $display("FAIL flush_state: got v=%b rw=%b mw=%b rd=%0d rdy=%b, expected 0/0/0/0/1",
               b0.valid_m, b0.regwrite_m, b0.memwrite_m, b0.rd_m, b0.ready_e);
    end
    ready_m = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (b0.valid_m !== 1'b0) begin errors++; $display("FAIL flush_after: got valid_m=%b rd_m=%0d, expected 0", b0.valid_m, b0.rd_m); end
    end
  endtask

  task automatic test_gating();
    set_in(1'b0, 5'd7, 32'h77);
    ready_m = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if ({b0.valid_m, b0.regwrite_m, b0.memwrite_m, b0.rd_m} !== 8'd0) begin
        errors++;
        $display("FAIL gating: got v=%b rw=%b mw=%b rd=%0d, expected all 0", b0.valid_m, b0.regwrite_m, b0.memwrite_m, b0.rd_m);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready_m = 1'b0;
    set_in(1'b1, 5'd1, 32'hA);
    tick();
    set_in(1'b0, 5'd0, 32'd0);
    checks++;
    if (stall_cnt !== 16'd0 || b0.valid_m !== 1'b1) begin
      errors++;
      $display("FAIL stall_start: got cnt=%0d valid_m=%b, expected 0/1", stall_cnt, b0.valid_m);
    end
    repeat (10) tick();
    checks++;
    if (stall_cnt !== 16'd10 || stall_cnt4 !== 4'd10) begin
      errors++;
      $display("FAIL stall_10: got %0d/%0d, expected 10/10", stall_cnt, stall_cnt4);
    end
    repeat (10) tick();
    checks++;
    if (stall_cnt !== 16'd20 || stall_cnt4 !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat: got %0d/%0d, expected 20/15", stall_cnt, stall_cnt4);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 16'd21 || stall_cnt4 !== 4'd15 || b0.valid_m !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: got %0d/%0d valid_m=%b, expected 21/15/0", stall_cnt, stall_cnt4, b0.valid_m);
    end
  endtask

  task automatic test_random();
    logic r, e;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 2) != 0, 5'($urandom), $urandom);
      ready_m = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 63) == 0;
      r = ready_m;
      e = b0.ready_e;
      ready_m = ~r;
      #1;
      checks++;
      if (b0.ready_e !== e) begin errors++; $display("FAIL rand_ready_path: got ready_e=%b, expected %b", b0.ready_e, e); end
      ready_m = r;
      tick();
    end
    flush = 1'b0;
    set_in(1'b0, 5'd0, 32'd0);
    ready_m = 1'b1;
    repeat (3) tick();
    checks++;
    if (q.size() != 0 || b0.valid_m !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending valid_m=%b, expected 0/0", q.size(), b0.valid_m);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_gating();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_em_elastic.md
Name: reg_em_elastic

Overview:
- Parametrised EX/MEM pipeline register for the pipelined RISC-V core. Successor to the fixed-width, always-enabled EX/MEM register.
- Adds a valid/ready handshake and a 2-entry skid buffer, so back-pressure from the memory stage does not drop instructions.
- Adds a synchronous flush for branch mispredict or trap.
- Adds a saturating stall counter for performance debug.
- Sits between the ALU stage and the data-memory stage.

Parameters:
- XLEN, 32, datapath width (aluresult, writedata, pcplus4)
- REGW, 5, register-index width
- RSW, 2, resultsrc width
- CNTW, 16, stall-counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; kills all held entries
- valid_e  in  1  EX-side instruction valid
- ready_e  out  1  stage can accept from EX
- regwrite_e  in  1  control field
- resultsrc_e  in  RSW  control field
- memwrite_e  in  1  control field
- aluresult  in  XLEN  ALU result
- writedata_e  in  XLEN  store data
- rd_e  in  REGW  destination register
- pcplus4_e  in  XLEN  PC+4
- valid_m  out  1  MEM-side instruction valid
- ready_m  in  1  MEM stage accepts
- regwrite_m  out  1  regwrite, gated by valid_m
- resultsrc_m  out  RSW  control field
- memwrite_m  out  1  memwrite, gated by valid_m
- aluresult_m  out  XLEN  ALU result
- writedata_m  out  XLEN  store data
- rd_m  out  REGW  destination register; forced 0 when valid_m=0 (hazard-safe)
- pcplus4_m  out  XLEN  PC+4
- stall_cnt  out  CNTW  cycles with valid_m=1 and ready_m=0, saturating

Behaviour:
- Reset: rst_n low asynchronously clears both entries and all valid bits. All outputs read 0 except ready_e, which reads 1. stall_cnt=0. Release is synchronous to clk.
- Storage: main entry drives the *_m outputs. Skid entry holds one extra payload.
- States are encoded by the valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Transfer definitions: fire_in = valid_e & ready_e; fire_out = valid_m & ready_m.
- ready_e = !skid_valid. It is a registered state bit; there is no combinational path from ready_m to ready_e.
- Transitions, when flush=0:
  - EMPTY + fire_in -> ONE; payload loads into main.
  - ONE + fire_in + fire_out -> ONE; main reloads with the new payload.
  - ONE + fire_in + !fire_out -> FULL; payload loads into skid.
  - ONE + !fire_in + fire_out -> EMPTY.
  - ONE + neither -> ONE.
  - FULL + fire_out -> ONE; skid moves to main. fire_in is impossible in FULL.
  - FULL + !fire_out -> FULL.
- Latency: 1 cycle from fire_in to valid_m when the stage is empty. Sustained throughput is 1 per cycle while ready_m=1.
- Ordering: strictly FIFO. Skid contents always reach main before any newer entry.
- Flush:
  - Next state is EMPTY regardless of other inputs.
  - A fire_in in the flush cycle is discarded.
  - A fire_out in the flush cycle still counts as consumed by MEM.
  - ready_e is 1 in the following cycle.
- Gating: regwrite_m, memwrite_m and rd_m are forced to 0 when valid_m=0. Other payload outputs hold their last value; don't-care when invalid.
- Data regs: payload registers load only on the write events above. No enable-free clocking of data.
- stall_cnt: increments when valid_m & !ready_m, and saturates at 2^CNTW-1. It is not cleared by flush; only by reset.
- Reset mid-operation: all in-flight entries are lost, with no partial outputs.

Decomposition:
- Shared package (riscv_pipe_pkg):
  - XLEN, REGW and RSW defaults.
  - A struct/concatenation ordering for the EX/MEM payload {regwrite, resultsrc, memwrite, aluresult, writedata, rd, pcplus4}, so the ID/EX and MEM/WB successors reuse it.
- One natural sub-module: pipe_skid_buf. It is a generic payload-width-parametrised 2-entry skid buffer with flush.
- reg_em_elastic itself:
  - packs the fields into the payload,
  - instantiates pipe_skid_buf,
  - gates the control outputs,
  - owns stall_cnt.

Test Plan:
- Reset, then streaming, then reset again:
  - During rst_n=0, all outputs read 0 and ready_e=1.
  - Then hold ready_m=1 and drive valid_e with aluresult=FFFF0001, then FFFF0100 on consecutive cycles. Each appears on aluresult_m exactly 1 cycle later; valid_m stays 1.
  - Asserting rst_n=0 mid-stream immediately drops valid_m to 0.
- Back-pressure:
  - Set ready_m=0 and send three instructions (rd=17, 9, 3). ready_e falls after the second; the third is held at EX.
  - Raising ready_m delivers rd_m=17, 9, 3 in order with no loss or duplication.
- Flush while FULL: flush=1 with valid_e=1 (rd=5) -> next cycle valid_m=0, regwrite_m=0, memwrite_m=0, rd_m=0, ready_e=1. rd=5 never appears.
- Gating: present regwrite_e=1, memwrite_e=1 with valid_e=0 -> regwrite_m=0 and memwrite_m=0 on every subsequent cycle.
- stall_cnt:
  - Hold valid_m=1 with ready_m=0 for 10 cycles -> stall_cnt=10.
  - With CNTW=4, 20 stalled cycles -> stall_cnt saturates at 15.
- Random valid_e/ready_m over 2000 cycles with a scoreboard: output sequence equals the accepted input sequence, and ready_e never depends combinationally on ready_m.
